// File: rtl/seg_stim_pkg.sv
// Shared types and default widths for the stimulus ramp sequencer.
package seg_stim_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RAMP = 2'd1,
        HOLD = 2'd2
    } stim_st_t;

    localparam int DEF_NUM_CH = 4;
    localparam int DEF_WIDTH  = 16;
    localparam int DEF_STEP_W = 12;
    localparam int DEF_PER_W  = 20;
    localparam int DEF_HOLD_W = 24;

endpackage

// File: rtl/stim_ramp_ch.sv
// One stimulus channel: slew-limited ramp to a loaded target, programmable hold,
// then a single-clock done pulse. Abort freezes the value and returns to IDLE.
module stim_ramp_ch
    import seg_stim_pkg::*;
#(
    parameter int                      WIDTH    = DEF_WIDTH,
    parameter int                      STEP_W   = DEF_STEP_W,
    parameter int                      PER_W    = DEF_PER_W,
    parameter int                      HOLD_W   = DEF_HOLD_W,
    parameter logic signed [WIDTH-1:0] INIT_VAL = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ld,
    input  logic signed [WIDTH-1:0] ld_target,
    input  logic [STEP_W-1:0]       ld_step,
    input  logic [PER_W-1:0]        ld_period,
    input  logic [HOLD_W-1:0]       ld_hold,
    input  logic                    abort,
    output logic signed [WIDTH-1:0] val,
    output logic                    busy,
    output logic                    done
);

    // Wide enough for |target-val| (WIDTH+1 bits) and the full step, plus a sign bit.
    localparam int MW = (WIDTH + 1 > STEP_W) ? WIDTH + 1 : STEP_W;
    localparam int SW = MW + 1;

    stim_st_t                st_q,   st_d;
    logic signed [WIDTH-1:0] val_q,  val_d;
    logic signed [WIDTH-1:0] tgt_q,  tgt_d;
    logic [STEP_W-1:0]       step_q, step_d;
    logic [PER_W-1:0]        per_q,  per_d;
    logic [PER_W-1:0]        pre_q,  pre_d;
    logic [HOLD_W-1:0]       hold_q, hold_d;
    logic [HOLD_W-1:0]       hcnt_q, hcnt_d;
    logic                    done_q, done_d;

    logic signed [SW-1:0]    val_x, step_x, diff, mag;
    logic signed [WIDTH-1:0] nxt;
    logic                    tick;

    assign tick = (pre_q == per_q);

    always_comb begin
        val_x  = SW'(val_q);
        step_x = SW'(step_q);
        diff   = SW'(tgt_q) - val_x;
        mag    = diff[SW-1] ? -diff : diff;
        if (step_q == '0 || mag <= step_x) begin
            nxt = tgt_q;
        end else begin
            nxt = WIDTH'(diff[SW-1] ? val_x - step_x : val_x + step_x);
        end
    end

    always_comb begin
        // NOTE: every signal gets its hold value first, so no branch can infer a latch.
        st_d   = st_q;
        val_d  = val_q;
        tgt_d  = tgt_q;
        step_d = step_q;
        per_d  = per_q;
        pre_d  = pre_q;
        hold_d = hold_q;
        hcnt_d = hcnt_q;
        done_d = 1'b0;

        if (abort) begin
            st_d = IDLE;
        end else if (ld) begin
            tgt_d  = ld_target;
            step_d = ld_step;
            per_d  = ld_period;
            hold_d = ld_hold;
            pre_d  = '0;
            hcnt_d = '0;
            st_d   = RAMP;
        end else begin
            case (st_q)
                RAMP: begin
                    if (tick) begin
                        pre_d = '0;
                        val_d = nxt;
                        if (nxt == tgt_q) begin
                            st_d   = HOLD;
                            hcnt_d = '0;
                        end
                    end else begin
                        pre_d = pre_q + 1'b1;
                    end
                end
                HOLD: begin
                    if (hcnt_q == hold_q) begin
                        st_d   = IDLE;
                        done_d = 1'b1;
                    end else begin
                        hcnt_d = hcnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q   <= IDLE;
            val_q  <= INIT_VAL;
            tgt_q  <= INIT_VAL;
            step_q <= '0;
            per_q  <= '0;
            pre_q  <= '0;
            hold_q <= '0;
            hcnt_q <= '0;
            done_q <= 1'b0;
        end else begin
            st_q   <= st_d;
            val_q  <= val_d;
            tgt_q  <= tgt_d;
            step_q <= step_d;
            per_q  <= per_d;
            pre_q  <= pre_d;
            hold_q <= hold_d;
            hcnt_q <= hcnt_d;
            done_q <= done_d;
        end
    end

    assign val  = val_q;
    assign busy = (st_q != IDLE);
    assign done = done_q;

endmodule

// File: rtl/stim_ramp_seq.sv
// Multi-channel stimulus ramp sequencer: decodes the load channel and fans abort
// out to NUM_CH independent ramp channels.
module stim_ramp_seq
    import seg_stim_pkg::*;
#(
    parameter int                      NUM_CH   = DEF_NUM_CH,
    parameter int                      WIDTH    = DEF_WIDTH,
    parameter int                      STEP_W   = DEF_STEP_W,
    parameter int                      PER_W    = DEF_PER_W,
    parameter int                      HOLD_W   = DEF_HOLD_W,
    parameter logic signed [WIDTH-1:0] INIT_VAL = '0
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic                                          ld,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] ld_ch,
    input  logic signed [WIDTH-1:0]                       ld_target,
    input  logic [STEP_W-1:0]                             ld_step,
    input  logic [PER_W-1:0]                              ld_period,
    input  logic [HOLD_W-1:0]                             ld_hold,
    input  logic                                          abort,
    output logic [NUM_CH*WIDTH-1:0]                       val,
    output logic [NUM_CH-1:0]                             busy,
    output logic [NUM_CH-1:0]                             done
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic ch_ld;

        // Indices beyond NUM_CH-1 match no channel and are dropped here.
        assign ch_ld = ld && (ld_ch == CH_W'(i));

        stim_ramp_ch #(
            .WIDTH    (WIDTH),
            .STEP_W   (STEP_W),
            .PER_W    (PER_W),
            .HOLD_W   (HOLD_W),
            .INIT_VAL (INIT_VAL)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .ld        (ch_ld),
            .ld_target (ld_target),
            .ld_step   (ld_step),
            .ld_period (ld_period),
            .ld_hold   (ld_hold),
            .abort     (abort),
            .val       (val[i*WIDTH +: WIDTH]),
            .busy      (busy[i]),
            .done      (done[i])
        );
    end

endmodule

// File: tb/tb_stim_ramp_seq.sv
// Scoreboard bench: each load precomputes the channel's value/done trajectory from
// the ramp rules; a negedge monitor pops and compares whenever an output moves.
module tb_stim_ramp_seq;

    localparam int NC  = 4;
    localparam int NG  = 5;        // four channels of dut0 plus the single channel of dut1
    localparam int W   = 16;
    localparam int INF = 1 << 30;

    typedef struct {
        int cyc;
        bit is_done;
        int value;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic               ld = 1'b0, abort = 1'b0;
    logic [1:0]         ld_ch = '0;
    logic signed [15:0] ld_target = '0;
    logic [11:0]        ld_step = '0;
    logic [19:0]        ld_period = '0;
    logic [23:0]        ld_hold = '0;
    logic [63:0]        val;
    logic [3:0]         busy, done;

    logic               ld1 = 1'b0, abort1 = 1'b0;
    logic [0:0]         ld_ch1 = '0;
    logic signed [15:0] ld_target1 = '0;
    logic [11:0]        ld_step1 = '0;
    logic [19:0]        ld_period1 = '0;
    logic [23:0]        ld_hold1 = '0;
    logic [15:0]        val1;
    logic [0:0]         busy1, done1;

    stim_ramp_seq u_dut (
        .clk(clk), .rst_n(rst_n), .ld(ld), .ld_ch(ld_ch), .ld_target(ld_target),
        .ld_step(ld_step), .ld_period(ld_period), .ld_hold(ld_hold), .abort(abort),
        .val(val), .busy(busy), .done(done)
    );

    stim_ramp_seq #(.NUM_CH(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .ld(ld1), .ld_ch(ld_ch1), .ld_target(ld_target1),
        .ld_step(ld_step1), .ld_period(ld_period1), .ld_hold(ld_hold1), .abort(abort1),
        .val(val1), .busy(busy1), .done(done1)
    );

    always #5 clk = ~clk;

    int cyc;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h), cyc %0d",
                     name, $signed(act), act, $signed(exp), exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    ev_t evq [NG][$];
    int  base_v   [NG];
    int  prev_v   [NG];
    int  bz_start [NG];
    int  bz_end   [NG];

    function automatic int iabs(int x);
        return (x < 0) ? -x : x;
    endfunction

    task automatic model_reset();
        for (int g = 0; g < NG; g++) begin
            evq[g].delete();
            base_v[g]   = 0;
            prev_v[g]   = 0;
            bz_start[g] = INF;
            bz_end[g]   = 0;
        end
    endtask

    task automatic truncate(int g, int n);
        while (evq[g].size() > 0 && evq[g][evq[g].size()-1].cyc >= n)
            void'(evq[g].pop_back());
    endtask

    task automatic push_ev(int g, int c, bit d, int v);
        ev_t e;
        e.cyc = c; e.is_done = d; e.value = v;
        evq[g].push_back(e);
    endtask

    // Load taking effect on edge n: ramp from the value the channel holds at n.
    task automatic model_load(int g, int n, int t, int s, int p, int h);
        int v, c, k;
        truncate(g, n);
        v = base_v[g];
        for (int i = 0; i < evq[g].size(); i++)
            if (!evq[g][i].is_done) v = evq[g][i].value;
        if (!(bz_start[g] <= n - 1 && n - 1 < bz_end[g])) bz_start[g] = n;
        k = 1;
        forever begin
            c = n + k * (p + 1);
            if (s == 0 || iabs(t - v) <= s) begin
                if (t != v) push_ev(g, c, 1'b0, t);
                break;
            end
            v = (t > v) ? v + s : v - s;
            push_ev(g, c, 1'b0, v);
            k++;
        end
        push_ev(g, c + h + 1, 1'b1, 0);
        bz_end[g] = c + h + 1;
    endtask

    task automatic model_abort(int a);
        for (int g = 0; g < NC; g++) begin
            truncate(g, a);
            if (bz_end[g] > a) bz_end[g] = a;
        end
    endtask

    function automatic int done_cyc(int g);
        int r = -1;
        for (int i = 0; i < evq[g].size(); i++)
            if (evq[g][i].is_done) r = evq[g][i].cyc;
        return r;
    endfunction

    function automatic bit all_empty();
        for (int g = 0; g < NG; g++)
            if (evq[g].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int get_val(int g);
        logic signed [15:0] t;
        if (g < NC) t = val[g*W +: W];
        else        t = val1;
        return int'(t);
    endfunction

    function automatic bit get_done(int g);
        return (g < NC) ? done[g] : done1[0];
    endfunction

    function automatic bit get_busy(int g);
        return (g < NC) ? busy[g] : busy1[0];
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            for (int g = 0; g < NG; g++) begin
                int  v;
                bit  bexp;
                ev_t e;
                v    = get_val(g);
                bexp = (bz_start[g] <= cyc) && (cyc < bz_end[g]);
                check($sformatf("ch%0d_busy", g), 64'(get_busy(g)), 64'(bexp));
                while (evq[g].size() > 0 && evq[g][0].cyc < cyc) begin
                    check($sformatf("ch%0d_missed_event_cyc", g), cyc, evq[g][0].cyc);
                    void'(evq[g].pop_front());
                end
                if (v != prev_v[g]) begin
                    if (evq[g].size() == 0) begin
                        check($sformatf("ch%0d_unexpected_val", g), v, prev_v[g]);
                    end else begin
                        e = evq[g].pop_front();
                        check($sformatf("ch%0d_val_cyc", g), cyc, e.cyc);
                        check($sformatf("ch%0d_val_kind", g), 0, 64'(e.is_done));
                        check($sformatf("ch%0d_val", g), v, e.value);
                        base_v[g] = e.value;
                    end
                end
                if (get_done(g)) begin
                    if (evq[g].size() == 0) begin
                        check($sformatf("ch%0d_unexpected_done", g), 1, 0);
                    end else begin
                        e = evq[g].pop_front();
                        check($sformatf("ch%0d_done_cyc", g), cyc, e.cyc);
                        check($sformatf("ch%0d_done_kind", g), 1, 64'(e.is_done));
                    end
                end
                prev_v[g] = v;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cycle();
        @(negedge clk);
        ld = 1'b0; abort = 1'b0; ld1 = 1'b0;
    endtask

    task automatic wait_cycles(int n);
        repeat (n) cycle();
    endtask

    task automatic load(int ch, int t, int s, int p, int h);
        ld = 1'b1; ld_ch = 2'(ch); ld_target = 16'(t);
        ld_step = 12'(s); ld_period = 20'(p); ld_hold = 24'(h);
        if (!abort) model_load(ch, cyc + 1, t, s, p, h);
    endtask

    task automatic load1(int ch, int t, int s, int p, int h);
        ld1 = 1'b1; ld_ch1 = 1'(ch); ld_target1 = 16'(t);
        ld_step1 = 12'(s); ld_period1 = 20'(p); ld_hold1 = 24'(h);
        if (ch == 0) model_load(NC, cyc + 1, t, s, p, h);
    endtask

    task automatic do_abort();
        abort = 1'b1;
        model_abort(cyc + 1);
    endtask

    initial begin
        int dc, rch, rs;
        bit found;
        logic signed [15:0] rt;

        model_reset();
        #23;
        check("rst_val",   val,  64'd0);
        check("rst_busy",  busy, 64'd0);
        check("rst_done",  done, 64'd0);
        check("rst_val1",  val1, 64'd0);
        check("rst_busy1", busy1, 64'd0);
        check("rst_done1", done1, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_cycles(100);

        // ramp up on ch0, then ramp down negative on ch1 the very next clock
        load(0, 'h0FFF, 'h100, 9, 5); cycle();
        load(1, -300, 128, 0, 3);     cycle();
        wait_cycles(200);

        // target equal to current value: hold entered on first tick, value unchanged
        load(3, 0, 'h10, 2, 1); cycle();
        wait_cycles(10);

        // retarget ch2 once it reaches 0x200
        load(2, 'h800, 'h40, 0, 4); cycle();
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (get_val(2) == 'h200) found = 1'b1;
            else cycle();
        end
        check("retarget_reached_0x200", 64'(found), 64'd1);
        load(2, 0, 'h40, 0, 1); cycle();
        wait_cycles(20);

        // load landing on the same edge as done
        load(3, 'h100, 'h80, 1, 2); cycle();
        dc = done_cyc(3);
        for (int i = 0; i < 100 && cyc < dc - 1; i++) cycle();
        check("done_collision_align", cyc, dc - 1);
        load(3, -'h100, 'h100, 0, 0); cycle();
        wait_cycles(10);

        // abort mid-ramp on ch0 and ch3, with a coincident load to ch1
        load(0, 'h4000, 'h10, 1, 0);  cycle();
        load(3, -'h4000, 'h10, 1, 0); cycle();
        wait_cycles(30);
        do_abort();
        load(1, 'h1234, 'h10, 0, 0);
        cycle();
        wait_cycles(20);

        // single-channel build: out-of-range index ignored, step 0 jumps to target
        load1(1, 'h1234, 0, 0, 0); cycle();
        wait_cycles(5);
        load1(0, 'h7FFF, 0, 4, 2); cycle();
        wait_cycles(15);

        // asynchronous reset in the middle of ramps
        load(0, 'h2000, 'h100, 0, 0);  cycle();
        load(2, -'h2000, 'h100, 0, 0); cycle();
        wait_cycles(10);
        #2 rst_n = 1'b0;
        #1;
        check("arst_val",  val,  64'd0);
        check("arst_busy", busy, 64'd0);
        check("arst_done", done, 64'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        wait_cycles(5);

        // randomized loads and aborts
        for (int it = 0; it < 150; it++) begin
            if ($urandom_range(0, 11) == 0) begin
                do_abort();
                if ($urandom_range(0, 1) == 1) load($urandom_range(0, 3), 'h55, 'h100, 0, 0);
                cycle();
            end else begin
                rch = $urandom_range(0, 3);
                rt  = 16'($urandom);
                rs  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(256, 4095);
                load(rch, int'(rt), rs, $urandom_range(0, 5), $urandom_range(0, 6));
                cycle();
            end
            wait_cycles($urandom_range(0, 25));
        end

        for (int i = 0; i < 20000 && !all_empty(); i++) cycle();
        for (int g = 0; g < NG; g++)
            check($sformatf("ch%0d_queue_drained", g), evq[g].size(), 0);
        wait_cycles(5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
